// File: rtl/demux_pkg.sv
// demux_pkg: shared widths and types for the 1:8 byte demultiplexer
package demux_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W = 3;
  typedef logic [7:0] byte_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;
endpackage

// File: rtl/demux_slot_8bit.sv
// demux_slot_8bit: one channel's single-byte holding register with valid/ready handshake
module demux_slot_8bit
  import demux_pkg::*;
#(
  parameter byte_t RST_DATA = 8'h00
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  byte_t wr_data,
  input  logic  rd_ready,
  output byte_t data,
  output logic  valid,
  output logic  free
);
  assign free = !valid | rd_ready;
  // a write wins over a same-cycle drain; data is left in place when drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= RST_DATA;
      valid <= 1'b0;
    end else begin
      if (wr_en) data <= wr_data;
      valid <= wr_en | (valid & !rd_ready);
    end
  end
endmodule

// File: rtl/demux_1to8_8bit_reg.sv
// demux_1to8_8bit_reg: registered 1:8 byte demux with broadcast and per-channel flow control
module demux_1to8_8bit_reg
  import demux_pkg::*;
#(
  parameter int    CNT_W    = 16,
  parameter byte_t RST_DATA = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  byte_t            in_data,
  input  logic [SEL_W-1:0] sel,
  input  logic             bcast,
  output byte_t            out0,
  output byte_t            out1,
  output byte_t            out2,
  output byte_t            out3,
  output byte_t            out4,
  output byte_t            out5,
  output byte_t            out6,
  output byte_t            out7,
  output ch_mask_t         out_valid,
  input  ch_mask_t         out_ready,
  output logic [CNT_W-1:0] acc_cnt
);
  byte_t    data [NUM_CH];
  ch_mask_t slot_free;
  ch_mask_t tgt;
  ch_mask_t wr_en;
  logic     accept;
  // broadcast is all-or-nothing, so it needs every slot free at once
  assign in_ready = bcast ? &slot_free : slot_free[sel];
  assign accept   = in_valid & in_ready;
  assign tgt      = bcast ? '1 : ch_mask_t'(1) << sel;
  assign wr_en    = accept ? tgt : '0;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot_8bit #(.RST_DATA(RST_DATA)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[g]),
      .wr_data  (in_data),
      .rd_ready (out_ready[g]),
      .data     (data[g]),
      .valid    (out_valid[g]),
      .free     (slot_free[g])
    );
  end
  assign out0 = data[0];
  assign out1 = data[1];
  assign out2 = data[2];
  assign out3 = data[3];
  assign out4 = data[4];
  assign out5 = data[5];
  assign out6 = data[6];
  assign out7 = data[7];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= '0;
    else if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_demux_1to8_8bit_reg.sv
// tb_demux_1to8_8bit_reg: directed checks of routing, stalls, broadcast and counter wrap
module tb_demux_1to8_8bit_reg;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] sel;
  logic       bcast;
  logic [7:0] o [8];
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [3:0] acc_cnt;
  logic [3:0] exp_cnt;
  int total = 0;
  int bad = 0;

  demux_1to8_8bit_reg #(.CNT_W(4), .RST_DATA(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sel(sel), .bcast(bcast),
    .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]),
    .out4(o[4]), .out5(o[5]), .out6(o[6]), .out7(o[7]),
    .out_valid(out_valid), .out_ready(out_ready), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    in_valid = 1'b1; sel = 3'd1; bcast = 1'b0; in_data = 8'h77; out_ready = 8'h00;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_pre_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    total++; if (out_valid !== 8'h02 || o[1] !== 8'h77 || acc_cnt !== exp_cnt) begin bad++;
      $display("FAIL rst_pre_write: got v=%h d=%h c=%0d want v=02 d=77 c=%0d", out_valid, o[1], acc_cnt, exp_cnt); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 8'h00 || acc_cnt !== 4'd0) begin bad++;
      $display("FAIL rst_async: got v=%h c=%0d want v=00 c=0", out_valid, acc_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++; if (o[i] !== 8'h00) begin bad++; $display("FAIL rst_data%0d: got %h want 00", i, o[i]); end
    end
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    tick;
  endtask

  task automatic test_unicast;
    sel = 3'd5; in_data = 8'hA5; in_valid = 1'b1; out_ready = 8'h00;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL uni_ready: got %b want 1", in_ready); end
    tick;
    exp_cnt = exp_cnt + 4'd1;
    total++; if (out_valid !== 8'h20 || o[5] !== 8'hA5 || acc_cnt !== exp_cnt) begin bad++;
      $display("FAIL uni_write: got v=%h d=%h c=%0d want v=20 d=a5 c=%0d", out_valid, o[5], acc_cnt, exp_cnt); end
    in_data = 8'hA6;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL uni_full_ready: got %b want 0", in_ready); end
    tick;
    total++; if (out_valid !== 8'h20 || o[5] !== 8'hA5 || acc_cnt !== exp_cnt) begin bad++;
      $display("FAIL uni_stall: got v=%h d=%h c=%0d want v=20 d=a5 c=%0d", out_valid, o[5], acc_cnt, exp_cnt); end
    in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL uni_ready_novalid: got %b want 0", in_ready); end
    in_valid = 1'b1; out_ready = 8'h20;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL uni_drain_ready: got %b want 1", in_ready); end
    tick;
    exp_cnt = exp_cnt + 4'd1;
    total++; if (out_valid !== 8'h20 || o[5] !== 8'hA6 || acc_cnt !== exp_cnt) begin bad++;
      $display("FAIL uni_rewrite: got v=%h d=%h c=%0d want v=20 d=a6 c=%0d", out_valid, o[5], acc_cnt, exp_cnt); end
    in_valid = 1'b0;
    tick;
    out_ready = 8'h00;
    total++; if (out_valid !== 8'h00 || o[5] !== 8'hA6) begin bad++;
      $display("FAIL uni_drain: got v=%h d=%h want v=00 d=a6", out_valid, o[5]); end
  endtask

  task automatic test_back_to_back;
    out_ready = 8'h04; sel = 3'd2; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'h10 + 8'(k);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); end
      tick;
      exp_cnt = exp_cnt + 4'd1;
      total++; if (o[2] !== 8'h10 + 8'(k) || out_valid !== 8'h04 || acc_cnt !== exp_cnt) begin bad++;
        $display("FAIL b2b_data%0d: got d=%h v=%h c=%0d want d=%h v=04 c=%0d", k, o[2], out_valid, acc_cnt, 8'h10 + 8'(k), exp_cnt); end
    end
    in_valid = 1'b0;
    tick;
    out_ready = 8'h00;
    total++; if (out_valid !== 8'h00 || o[2] !== 8'h12) begin bad++;
      $display("FAIL b2b_drain: got v=%h d=%h want v=00 d=12", out_valid, o[2]); end
  endtask

  task automatic test_bcast_stall;
    sel = 3'd3; in_data = 8'h3C; in_valid = 1'b1; out_ready = 8'h00;
    tick;
    exp_cnt = exp_cnt + 4'd1;
    bcast = 1'b1; in_data = 8'h5A; sel = 3'd0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_stall_ready: got %b want 0", in_ready); end
    tick;
    total++; if (out_valid !== 8'h08 || o[3] !== 8'h3C || o[0] !== 8'h00 || acc_cnt !== exp_cnt) begin bad++;
      $display("FAIL bc_stall_hold: got v=%h d3=%h d0=%h c=%0d want v=08 d3=3c d0=00 c=%0d", out_valid, o[3], o[0], acc_cnt, exp_cnt); end
    out_ready = 8'h08;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_go_ready: got %b want 1", in_ready); end
    tick;
    exp_cnt = exp_cnt + 4'd1;
    in_valid = 1'b0; bcast = 1'b0; out_ready = 8'h00;
    total++; if (out_valid !== 8'hFF || acc_cnt !== exp_cnt) begin bad++;
      $display("FAIL bc_write: got v=%h c=%0d want v=ff c=%0d", out_valid, acc_cnt, exp_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++; if (o[i] !== 8'h5A) begin bad++; $display("FAIL bc_data%0d: got %h want 5a", i, o[i]); end
    end
  endtask

  task automatic test_simul_write_drain;
    out_ready = 8'h80; sel = 3'd7; in_data = 8'h33; in_valid = 1'b1;
    tick;
    exp_cnt = exp_cnt + 4'd1;
    total++; if (o[7] !== 8'h33 || out_valid !== 8'hFF) begin bad++;
      $display("FAIL sim_pre: got d=%h v=%h want d=33 v=ff", o[7], out_valid); end
    in_data = 8'h44;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sim_ready: got %b want 1", in_ready); end
    tick;
    exp_cnt = exp_cnt + 4'd1;
    in_valid = 1'b0; out_ready = 8'h00;
    total++; if (o[7] !== 8'h44 || out_valid !== 8'hFF || acc_cnt !== exp_cnt) begin bad++;
      $display("FAIL sim_write: got d=%h v=%h c=%0d want d=44 v=ff c=%0d", o[7], out_valid, acc_cnt, exp_cnt); end
    for (int i = 0; i < 7; i++) begin
      total++; if (o[i] !== 8'h5A) begin bad++; $display("FAIL sim_other%0d: got %h want 5a", i, o[i]); end
    end
    out_ready = 8'hFF;
    tick;
    out_ready = 8'h00;
    total++; if (out_valid !== 8'h00 || o[7] !== 8'h44) begin bad++;
      $display("FAIL sim_drain_all: got v=%h d7=%h want v=00 d7=44", out_valid, o[7]); end
  endtask

  task automatic test_wrap;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    sel = 3'd0; out_ready = 8'h01; in_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_data = 8'(k);
      tick;
      exp_cnt = exp_cnt + 4'd1;
      total++; if (acc_cnt !== exp_cnt || o[0] !== 8'(k)) begin bad++;
        $display("FAIL wrap%0d: got c=%0d d=%h want c=%0d d=%h", k, acc_cnt, o[0], exp_cnt, 8'(k)); end
    end
    in_valid = 1'b0;
    total++; if (acc_cnt !== 4'd1) begin bad++; $display("FAIL wrap_final: got %0d want 1", acc_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; sel = 3'd0; bcast = 1'b0; out_ready = 8'h00;
    exp_cnt = 4'd0;
    #12 rst_n = 1'b1;
    tick;
    test_reset;
    test_unicast;
    test_back_to_back;
    test_bcast_stall;
    test_simul_write_drain;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
